// File: rtl/bf_pkg.sv
// Brainfuck opcode bytes, loader/receiver state encodings and the opcode filter.
// Shared between the program loader and cpu_core.
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;

  typedef enum logic [1:0] {L_IDLE, L_RECV, L_FILL, L_DONE} load_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic is_bf_op(input logic [7:0] b);
    return b inside {OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_LOOP, OP_END, OP_OUT, OP_IN};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rxd, rejects start-bit glitches, samples at bit centres
// and emits a one-cycle rx_valid (good stop) or rx_frame_err (low stop).
module uart_rx
  import bf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       state_reg, state_next;
  logic            sync1_reg, sync2_reg, prev_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_reg;
  logic [7:0]      shift_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= RX_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (prev_reg && !sync2_reg) state_next = RX_START;
      // Line must still be low at mid start bit, otherwise it was a glitch.
      RX_START: if (cnt_reg == CNT_HALF) state_next = sync2_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_reg == CNT_FULL && bit_reg == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (cnt_reg == CNT_FULL) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      prev_reg     <= 1'b1;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync1_reg    <= rxd;
      sync2_reg    <= sync1_reg;
      prev_reg     <= sync2_reg;
      rx_valid     <= (state_reg == RX_STOP) && (cnt_reg == CNT_FULL) && sync2_reg;
      rx_frame_err <= (state_reg == RX_STOP) && (cnt_reg == CNT_FULL) && !sync2_reg;
      if (state_reg == RX_IDLE || state_next != state_reg || cnt_reg == CNT_FULL)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
      if (state_reg == RX_START)
        bit_reg <= '0;
      else if (state_reg == RX_DATA && cnt_reg == CNT_FULL) begin
        bit_reg   <= bit_reg + 1'b1;
        shift_reg <= {sync2_reg, shift_reg[7:1]};
      end
    end
  end

  always_comb rx_data = shift_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a Brainfuck program over UART, keeps only opcodes, checks bracket balance,
// writes it into program SPRAM from address 0 and zero-fills the remainder.
module uart_prog_loader
  import bf_pkg::*;
#(
  parameter int          PROG_ADDR_WIDTH = 14,
  parameter int          PROG_LEN        = 16383,
  parameter int          CLKS_PER_BIT    = 104,
  parameter logic [7:0]  END_BYTE        = 8'h21
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rxd,
  input  logic                       load_req,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       busy,
  output logic [PROG_ADDR_WIDTH-1:0] prog_count,
  output logic                       bracket_err,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int AW = PROG_ADDR_WIDTH;
  localparam logic [AW-1:0] LEN_FULL = AW'(PROG_LEN);

  load_state_t   state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   depth_reg;
  logic          rx_valid, rx_frame_err;
  logic [7:0]    rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .resetn       (resetn),
    .rxd          (uart_rxd),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  logic start_load, rx_op, rx_end, ptr_full, any_err;
  assign start_load = (state_reg == L_IDLE || state_reg == L_DONE) && load_req;
  assign rx_op      = rx_valid && (state_reg == L_RECV) && is_bf_op(rx_data);
  assign rx_end     = rx_valid && (state_reg == L_RECV) && (rx_data == END_BYTE);
  assign ptr_full   = (wr_ptr_reg == LEN_FULL);
  assign any_err    = bracket_err || overflow || frame_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= L_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      L_IDLE, L_DONE: if (start_load) state_next = L_RECV;
      L_RECV:         if (rx_end) state_next = L_FILL;
      L_FILL:         if (ptr_full) state_next = any_err ? L_IDLE : L_DONE;
      default:        state_next = L_IDLE;
    endcase
  end

  always_comb begin
    loaded = (state_reg == L_DONE);
    busy   = (state_reg == L_RECV) || (state_reg == L_FILL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_wr     <= '0;
      prog_count  <= '0;
      bracket_err <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      wr_ptr_reg  <= '0;
      depth_reg   <= '0;
    end else begin
      prog_we <= 1'b0;
      if (start_load) begin
        prog_count  <= '0;
        bracket_err <= 1'b0;
        overflow    <= 1'b0;
        frame_err   <= 1'b0;
        wr_ptr_reg  <= '0;
        depth_reg   <= '0;
      end else if (state_reg == L_RECV) begin
        if (rx_frame_err) frame_err <= 1'b1;
        if (rx_end && depth_reg != '0) bracket_err <= 1'b1;
        if (rx_op) begin
          if (ptr_full) overflow <= 1'b1;
          else begin
            prog_we    <= 1'b1;
            prog_addr  <= wr_ptr_reg;
            prog_wr    <= rx_data;
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            prog_count <= prog_count + 1'b1;
            // Unmatched ']' flags the error but leaves depth at zero.
            if (rx_data == OP_LOOP) depth_reg <= depth_reg + 1'b1;
            else if (rx_data == OP_END) begin
              if (depth_reg == '0) bracket_err <= 1'b1;
              else                 depth_reg <= depth_reg - 1'b1;
            end
          end
        end
      end else if (state_reg == L_FILL && !ptr_full) begin
        prog_we    <= 1'b1;
        prog_addr  <= wr_ptr_reg;
        prog_wr    <= 8'h00;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
    end
  end

endmodule
